// File: rtl/fft16_output_serializer.sv
// Snapshot of the 16 parallel FFT bins, streamed one bin per valid/ready transfer.
// Define FFT16_OUT_BITREV_EN to emit bins in bit-reversed snapshot order (natural frequency order).
module fft16_output_serializer #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [16*WIDTH-1:0] yr_in_flat,
   input  logic [16*WIDTH-1:0] yi_in_flat,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_re,
   output logic [WIDTH-1:0]   out_im,
   output logic [3:0]         out_idx,
   output logic               out_last,
   output logic               done,
   output logic               overrun
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic             cap, xfer, fin;
   logic [WIDTH-1:0] sr [16];
   logic [WIDTH-1:0] si [16];

   function automatic logic [3:0] bin_sel(input logic [3:0] k);
`ifdef FFT16_OUT_BITREV_EN
      return {k[0], k[1], k[2], k[3]};
`else
      return k;
`endif
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cap       = (state == IDLE) && start;
      xfer      = out_valid && out_ready;
      fin       = xfer && (cnt == 4'd15);
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SEND;
               cnt_nxt   = 4'd0;
            end
         end
         SEND: begin
            if (xfer) begin
               cnt_nxt = cnt + 4'd1;
               if (cnt == 4'd15) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < 16; j++) begin
            sr[j] <= '0;
            si[j] <= '0;
         end
      end else if (cap) begin
         for (int j = 0; j < 16; j++) begin
            sr[j] <= yr_in_flat[j*WIDTH +: WIDTH];
            si[j] <= yi_in_flat[j*WIDTH +: WIDTH];
         end
      end
   end

   // First word comes straight from the inputs: the snapshot is loading on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_idx   <= 4'd0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         done <= fin;
         if (start && (state == SEND)) overrun <= 1'b1;
         if (cap) begin
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_re    <= yr_in_flat[WIDTH-1:0];
            out_im    <= yi_in_flat[WIDTH-1:0];
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
         end else if (fin) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
         end else if (xfer) begin
            out_re   <= sr[bin_sel(cnt_nxt)];
            out_im   <= si[bin_sel(cnt_nxt)];
            out_idx  <= cnt_nxt;
            out_last <= (cnt_nxt == 4'd15);
         end
      end
   end

endmodule

// File: tb/tb_fft16_output_serializer.sv
// Bench for fft16_output_serializer: queue-based frame model plus directed scenarios.
// Honours FFT16_OUT_BITREV_EN for the expected bin order.
module tb_fft16_output_serializer;

   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [16*W-1:0] yr = '0;
   logic [16*W-1:0] yi = '0;
   logic            busy, out_valid, out_last, done, overrun;
   logic            out_ready = 1'b1;
   logic [W-1:0]    out_re, out_im;
   logic [3:0]      out_idx;

   fft16_output_serializer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .yr_in_flat(yr), .yi_in_flat(yi),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
      .out_last(out_last), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int re;
      int im;
      int idx;
      int last;
   } w_t;

   w_t q[$];
   w_t rec[$];
   int total = 0;
   int bad = 0;
   int m_done = 0;
   int m_ovr = 0;
   int done_seen = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int br(input int k);
      return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
   endfunction

   function automatic int perm(input int k);
`ifdef FFT16_OUT_BITREV_EN
      return br(k);
`else
      return k;
`endif
   endfunction

   function automatic int bin(input logic [16*W-1:0] f, input int j);
      logic signed [W-1:0] v;
      v = f[j*W +: W];
      return int'(v);
   endfunction

   // Model: a start while idle queues the 16 expected words; each transfer pops one.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_done = 0;
         m_ovr = 0;
      end else begin
         m_done = 0;
         if (q.size() != 0) begin
            if (start) m_ovr = 1;
            if (out_ready) begin
               void'(q.pop_front());
               if (q.size() == 0) m_done = 1;
            end
         end else if (start) begin
            for (int k = 0; k < 16; k++)
               q.push_back('{bin(yr, perm(k)), bin(yi, perm(k)), k, int'(k == 15)});
         end
      end
   end

   always @(negedge clk) begin
      chk("valid", int'(out_valid), int'(q.size() != 0));
      chk("busy", int'(busy), int'(q.size() != 0));
      chk("done", int'(done), m_done);
      chk("overrun", int'(overrun), m_ovr);
      if (q.size() != 0) begin
         chk("re", int'($signed(out_re)), q[0].re);
         chk("im", int'($signed(out_im)), q[0].im);
         chk("idx", int'(out_idx), q[0].idx);
         chk("last", int'(out_last), q[0].last);
      end
      if (out_valid && out_ready && !rst)
         rec.push_back('{int'($signed(out_re)), int'($signed(out_im)),
                         int'(out_idx), int'(out_last)});
      if (done) done_seen = 1;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int kind);
      for (int j = 0; j < 16; j++) begin
         case (kind)
            0: begin yr[j*W +: W] = W'(j * 100); yi[j*W +: W] = W'(-j); end
            1: begin yr[j*W +: W] = W'(1000 + j); yi[j*W +: W] = W'(j * 7); end
            default: begin yr[j*W +: W] = W'(j); yi[j*W +: W] = '0; end
         endcase
      end
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
   // inj_kind 1: start with new data at inj transfers; 2: reset at inj transfers.
   task automatic frame(input int kind, input int mode, input int inj,
                        input int inj_kind, output int ncyc);
      int t;
      bit fired;
      load(kind);
      rec.delete();
      done_seen = 0;
      fired = 0;
      t = 0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      ncyc = 1;
      while (!done && ncyc < 400) begin
         out_ready = (mode == 0) || (t % 3 == 0);
         if (!fired && inj_kind != 0 && rec.size() == inj) begin
            fired = 1;
            if (inj_kind == 1) begin
               load(1);
               start = 1'b1;
            end else begin
               rst = 1'b1;
            end
         end
         cycle();
         start = 1'b0;
         rst = 1'b0;
         t++;
         ncyc++;
         if (fired && inj_kind == 2) break;
      end
      if (!done && inj_kind != 2) chk("timeout", ncyc, -1);
      out_ready = 1'b1;
   endtask

   int n;
   int lastcnt;
   int exp6[16];

   initial begin
      // 1: reset then idle
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      repeat (3) cycle();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ovr", int'(overrun), 0);
      chk("rst_re", int'(out_re), 0);
      chk("rst_idx", int'(out_idx), 0);

      // 2: full-rate frame
      frame(0, 0, 0, 0, n);
      chk("start2done", n, 17);
      chk("t2_count", rec.size(), 16);
      lastcnt = 0;
      foreach (rec[k]) begin
         chk("t2_idx", rec[k].idx, k);
         lastcnt += rec[k].last;
      end
      chk("t2_lastcnt", lastcnt, 1);
      chk("t2_last15", rec[15].last, 1);
`ifdef FFT16_OUT_BITREV_EN
      chk("t2_re3", rec[3].re, 1200);
      chk("t2_im1", rec[1].im, -8);
`else
      chk("t2_re3", rec[3].re, 300);
      chk("t2_im1", rec[1].im, -1);
`endif
      cycle();
      chk("t2_done_1cyc", int'(done), 0);

      // 3: backpressure
      frame(0, 1, 0, 0, n);
      chk("t3_count", rec.size(), 16);
      foreach (rec[k]) chk("t3_idx", rec[k].idx, k);
      chk("t3_slow", int'(n > 40), 1);

      // 4: overrun at transfer 5, then a normal frame
      frame(0, 0, 5, 1, n);
      chk("t4_ovr", int'(overrun), 1);
      chk("t4_count", rec.size(), 16);
`ifdef FFT16_OUT_BITREV_EN
      chk("t4_re10", rec[10].re, 500);
`else
      chk("t4_re10", rec[10].re, 1000);
`endif
      frame(1, 0, 0, 0, n);
      chk("t4_new_re0", rec[0].re, 1000);
      chk("t4_new_count", rec.size(), 16);
      chk("t4_ovr_sticky", int'(overrun), 1);

      // 5: reset mid-stream at transfer 7
      frame(0, 0, 7, 2, n);
      chk("t5_valid", int'(out_valid), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_ovr", int'(overrun), 0);
      chk("t5_partial", rec.size(), 7);
      done_seen = 0;
      repeat (4) cycle();
      chk("t5_nodone", done_seen, 0);
      frame(0, 0, 0, 0, n);
      chk("t5_idx0", rec[0].idx, 0);
      chk("t5_count", rec.size(), 16);

      // 6: ordering of re=j data
`ifdef FFT16_OUT_BITREV_EN
      exp6 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
      for (int k = 0; k < 16; k++) exp6[k] = k;
`endif
      frame(2, 0, 0, 0, n);
      chk("t6_count", rec.size(), 16);
      for (int k = 0; k < 16 && k < rec.size(); k++) begin
         chk("t6_re", rec[k].re, exp6[k]);
         chk("t6_idx", rec[k].idx, k);
      end

      repeat (3) cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=%0t required=finish", $time);
      $fatal(1);
   end

endmodule
